// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and constants for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic {
        ST_IDLE,
        ST_ITER
    } state_t;

    // Replicated WIDTH times to form the divide-by-zero quotient.
    localparam logic DIV0_Q_BIT = 1'b1;

    function automatic logic is_iter_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative engine: radix-2 Booth multiply / non-restoring divide on magnitudes.
// Latency: load, then WIDTH step cycles; outputs show the post-step value combinationally.
// Backpressure: none; the controller issues step every cycle while iterating.
module alu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    // Two guard bits: Booth subtracting MIN, and the 2P +/- D range of the divider.
    localparam int AW = WIDTH + 2;

    logic [AW-1:0]    acc_q, acc_d, st_acc, m_ext, sum, shifted;
    logic [WIDTH-1:0] q_q, q_d, st_q, m_q, m_d, mag_a, mag_b, rem_fix;
    logic             q1_q, q1_d, st_q1;
    logic             mode_q, mode_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin : step_logic
        m_ext   = mode_q ? {2'b00, m_q} : {{2{m_q[WIDTH-1]}}, m_q};
        shifted = {acc_q[AW-2:0], q_q[WIDTH-1]};
        sum     = acc_q;
        st_acc  = acc_q;
        st_q    = q_q;
        st_q1   = q1_q;
        if (mode_q) begin
            sum    = acc_q[AW-1] ? (shifted + m_ext) : (shifted - m_ext);
            st_acc = sum;
            st_q   = {q_q[WIDTH-2:0], ~sum[AW-1]};
            st_q1  = 1'b0;
        end else begin
            case ({q_q[0], q1_q})
                2'b01:   sum = acc_q + m_ext;
                2'b10:   sum = acc_q - m_ext;
                default: sum = acc_q;
            endcase
            st_acc = {sum[AW-1], sum[AW-1:1]};
            st_q   = {sum[0], q_q[WIDTH-1:1]};
            st_q1  = q_q[0];
        end
    end

    always_comb begin : result_logic
        // A negative final partial remainder needs one restoring add; true remainder fits WIDTH bits.
        rem_fix   = st_acc[WIDTH-1:0] + (st_acc[AW-1] ? m_q : '0);
        product   = {st_acc[WIDTH-1:0], st_q};
        quotient  = qneg_q ? -st_q : st_q;
        remainder = rneg_q ? -rem_fix : rem_fix;
        last      = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin : next_state
        mag_a  = a[WIDTH-1] ? -a : a;
        mag_b  = b[WIDTH-1] ? -b : b;
        acc_d  = acc_q;
        q_d    = q_q;
        q1_d   = q1_q;
        m_d    = m_q;
        mode_d = mode_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d  = '0;
            q1_d   = 1'b0;
            cnt_d  = '0;
            mode_d = mode_div;
            qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d = a[WIDTH-1];
            if (mode_div) begin
                q_d = mag_a;
                m_d = mag_b;
            end else begin
                q_d = b;
                m_d = a;
            end
        end else if (step) begin
            acc_d = st_acc;
            q_d   = st_q;
            q1_d  = st_q1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_q  <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            m_q    <= '0;
            mode_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            m_q    <= m_d;
            mode_q <= mode_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops plus iterative MUL/DIV behind a start/busy/done handshake.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL/DIV; result held between completions.
// Backpressure: start is ignored while busy; no queueing.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [4:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   result
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 bzero_q, bzero_d;
    logic                 is_div_q, is_div_d;

    logic                 load, step, last;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quotient, remainder;
    logic [WIDTH-1:0]     single_val;
    logic [SHW-1:0]       rot_amt, rot_neg;
    logic                 b_big;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock     (clock),
        .clear     (clear),
        .load      (load),
        .step      (step),
        .mode_div  (op == OP_DIV),
        .a         (a),
        .b         (b),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin : single_cycle
        b_big   = (b >= WIDTH'(WIDTH));
        rot_amt = b[SHW-1:0];
        // -amt mod WIDTH; a zero amount makes both halves equal to a.
        rot_neg = -rot_amt;
        single_val = '0;
        case (op)
            OP_ADD:  single_val = a + b;
            OP_SUB:  single_val = a - b;
            OP_AND:  single_val = a & b;
            OP_OR:   single_val = a | b;
            OP_SHR:  single_val = b_big ? '0 : (a >> b);
            OP_SHRA: single_val = b_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_SHL:  single_val = b_big ? '0 : (a << b);
            OP_ROR:  single_val = (a >> rot_amt) | (a << rot_neg);
            OP_ROL:  single_val = (a << rot_amt) | (a >> rot_neg);
            OP_NEG:  single_val = -a;
            OP_NOT:  single_val = ~a;
            default: single_val = '0;
        endcase
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        result_d   = result_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        a_d        = a_q;
        bzero_d    = bzero_q;
        is_div_d   = is_div_q;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_op(op)) begin
                        load     = 1'b1;
                        state_d  = ST_ITER;
                        a_d      = a;
                        bzero_d  = (b == '0);
                        is_div_d = (op == OP_DIV);
                    end else begin
                        result_d   = {{WIDTH{1'b0}}, single_val};
                        done_d     = 1'b1;
                        div_zero_d = 1'b0;
                    end
                end
            end
            ST_ITER: begin
                step = 1'b1;
                if (last) begin
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                    div_zero_d = 1'b0;
                    if (!is_div_q) begin
                        result_d = product;
                    end else if (bzero_q) begin
                        result_d   = {a_q, {WIDTH{DIV0_Q_BIT}}};
                        div_zero_d = 1'b1;
                    end else begin
                        result_d = {remainder, quotient};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ITER);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= '0;
            bzero_q    <= 1'b0;
            is_div_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            div_zero_q <= div_zero_d;
            a_q        <= a_d;
            bzero_q    <= bzero_d;
            is_div_q   <= is_div_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        start, start8;
    logic [4:0]  op, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        busy, done, div_zero;
    logic        busy8, done8, div_zero8;
    logic [63:0] result;
    logic [15:0] result8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .result(result)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .result(result8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic sc(input string tag, input logic [4:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [63:0] exp);
        issue(o, x, y);
        check(tag, result, exp);
    endtask

    task automatic iter(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
        int cyc;
        issue(o, x, y);
        cyc = 0;
        while (done !== 1'b1 && cyc < 64) begin
            @(posedge clock);
            #1 cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd32);
        check(tag, result, exp);
    endtask

    task automatic iter8(input string tag, input logic [4:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] exp);
        int cyc;
        @(negedge clock);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clock);
        #1 start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 32) begin
            @(posedge clock);
            #1 cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd8);
        check(tag, 64'(result8), 64'(exp));
    endtask

    initial begin
        int pulses;
        clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", result, 64'h0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clock) clear = 1'b0;

        // ADD overflow wraps into lo only; done lasts one cycle and result holds
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        check("add_done", 64'(done), 64'd1);
        check("add_res", result, 64'h0000_0000_8000_0000);
        a = 32'h1234; b = 32'h5678; op = OP_SUB;
        @(posedge clock);
        #1;
        check("add_done_pulse", 64'(done), 64'd0);
        check("add_hold", result, 64'h0000_0000_8000_0000);
        sc("sub", OP_SUB, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE);

        // MUL -3*7 with a start at E5 that must be ignored
        issue(OP_MUL, 32'hFFFF_FFFD, 32'd7);
        check("mul_busy_e0", 64'(busy), 64'd1);
        repeat (4) @(posedge clock);
        #1 begin op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1; end
        @(posedge clock);
        #1 start = 1'b0;
        check("mul_busy_e5", 64'(busy), 64'd1);
        repeat (26) @(posedge clock);
        #1;
        check("mul_no_done_e31", 64'(done), 64'd0);
        check("mul_busy_e31", 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        check("mul_done_e32", 64'(done), 64'd1);
        check("mul_busy_e32", 64'(busy), 64'd0);
        check("mul_res", result, 64'hFFFF_FFFF_FFFF_FFEB);

        // issued during the done cycle: back-to-back
        sc("b2b_or", OP_OR, 32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F);

        iter("mul_max", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        iter("div_neg", OP_DIV, 32'hFFFF_FFEF, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD);
        check("div_neg_dz", 64'(div_zero), 64'd0);
        iter("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        iter("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        sc("ror_1", OP_ROR, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
        sc("ror_32", OP_ROR, 32'h8000_0001, 32'd32, 64'h0000_0000_8000_0001);
        sc("rol_33", OP_ROL, 32'h8000_0001, 32'd33, 64'h0000_0000_0000_0003);
        sc("shra_40", OP_SHRA, 32'h8000_0001, 32'd40, 64'h0000_0000_FFFF_FFFF);
        sc("shra_4", OP_SHRA, 32'h8000_0001, 32'd4, 64'h0000_0000_F800_0000);
        sc("shl_32", OP_SHL, 32'h8000_0001, 32'd32, 64'h0);
        sc("shr_4", OP_SHR, 32'h8000_0001, 32'd4, 64'h0000_0000_0800_0000);
        sc("neg", OP_NEG, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFB);
        sc("not", OP_NOT, 32'h8000_0001, 32'd0, 64'h0000_0000_7FFF_FFFE);
        sc("bad_op", 5'b11111, 32'h1234_5678, 32'h1, 64'h0);

        iter("div_by0", OP_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
        check("div_by0_dz", 64'(div_zero), 64'd1);
        sc("and", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0);
        check("and_dz_clr", 64'(div_zero), 64'd0);
        iter("div_by0_b", OP_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);

        // clear mid-divide: everything back to reset values, no late done
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clock);
        #1 clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_result", result, 64'h0);
        check("clr_dz", 64'(div_zero), 64'd0);
        @(negedge clock) clear = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 if (done) pulses++;
        end
        check("clr_no_done", 64'(pulses), 64'd0);
        sc("add_after_clr", OP_ADD, 32'd2, 32'd2, 64'h0000_0000_0000_0004);

        iter8("mul8_min", OP_MUL, 8'h80, 8'h80, 16'h4000);
        iter8("div8_min_m1", OP_DIV, 8'h80, 8'hFF, 16'h0080);
        check("div8_dz", 64'(div_zero8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the RISC datapath, replacing the purely combinational ALU between the Y register/bus and the Z register pair. Single-cycle operations complete in one clock. Multiply (radix-2 Booth) and divide (non-restoring) run iteratively over WIDTH cycles instead of as large combinational arrays. A start/busy/done handshake lets the control unit stall until the Z result is valid.

## Interface
- WIDTH, 32: operand width; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH): rotate-amount bits used from b.

- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy = 0.
- op  in  5  operation code, sampled with start.
- a  in  WIDTH  operand A (Y register side), sampled with start.
- b  in  WIDTH  operand B (bus side), sampled with start.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse; result valid.
- div_zero  out  1  last divide had b = 0; held until next completion.
- result  out  2*WIDTH  {hi, lo}; held until the next completion.

## Operation
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. Any other op produces result 0 and completes in one cycle.
- Single-cycle ops write lo = the value and hi = 0:
  - ADD/SUB wrap modulo 2^WIDTH.
  - NEG = two's complement of a; NOT = ~a.
- Shift rules:
  - SHR/SHL use the full b. If b ≥ WIDTH, the value is 0.
  - SHRA: if b ≥ WIDTH, the value is WIDTH copies of a[WIDTH-1].
  - ROR/ROL use b[SHW-1:0]. An amount of 0 returns a.
- MUL: signed × signed, full 2*WIDTH product in {hi, lo}. Radix-2 Booth, one bit per cycle.
- DIV: signed, quotient truncated toward zero, remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
  - Non-restoring iteration on magnitudes, one bit per cycle. Remainder correction and sign fix are applied at the final write.
  - b = 0: lo = all ones, hi = a, div_zero = 1.
  - a = MIN, b = -1: lo = MIN, hi = 0, div_zero = 0.
- div_zero is cleared by any non-DIV completion or by a DIV with b ≠ 0.
- FSM states: IDLE, ITER.
  - IDLE with start and a single-cycle op: write result, pulse done, stay in IDLE.
  - IDLE with start and MUL/DIV: latch operands, clear the counter, go to ITER.
  - ITER: advance one step per cycle. When the counter reaches WIDTH-1, write result, pulse done, return to IDLE.

## Timing
- Reset values: result 0, done 0, busy 0, div_zero 0, state IDLE, counter 0.
- Label the edge at which start is sampled E0.
- Single-cycle op: result and done are registered at E0. done is high for exactly one cycle.
- MUL/DIV:
  - busy is high after E0 and drops after E_WIDTH.
  - result and done are registered at E_WIDTH, so latency is WIDTH cycles.
- start while busy is ignored: no queueing, and the operands in flight are unaffected.
- start on the same cycle done pulses from IDLE is accepted (back-to-back issue).
- clear mid-iteration aborts immediately: outputs return to reset values, and no done is issued for the aborted operation.
- result does not change between completions, even if a/b/op change.

## Structure
- Package alu_pkg:
  - opcode localparams (OP_ADD … OP_NOT);
  - state enum (ST_IDLE, ST_ITER);
  - helper constant for the div-by-zero quotient (all ones).
- Sub-module alu_iter_unit: a shared iterative engine (accumulator, partial-remainder/multiplier register, counter), selected by a mul/div mode bit. It has inputs load and step, and outputs last and product/quotient/remainder. Single-cycle logic and the FSM stay in seq_alu.

## Test plan
- ADD a=0x7FFFFFFF, b=1 -> done one cycle after start; result = 0x0000_0000_8000_0000. Then SUB 5−7 -> lo = 0xFFFFFFFE.
- MUL a=−3 (0xFFFFFFFD), b=7 -> busy for 32 cycles, done at E32; result = 0xFFFFFFFF_FFFFFFEB. A start at E5 is ignored.
- DIV a=−17, b=5 -> lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFE (−2). DIV a=9, b=0 -> lo = 0xFFFFFFFF, hi = 9, div_zero = 1.
- Shifts with a=0x80000001:
  - ROR b=1 -> 0xC0000000;
  - ROL b=33 -> 0x00000003;
  - SHRA b=40 -> 0xFFFFFFFF;
  - SHL b=32 -> 0.
- Assert clear at E10 of a DIV -> busy, done, result, div_zero all 0 immediately. The next ADD 2+2 yields 4 normally.
- Instantiate with WIDTH=8: MUL −128×−128 -> result 16'h4000 after 8 cycles. DIV −128/−1 -> lo = 0x80, hi = 0.
